// File: rtl/itch_pkg.sv
// Shared trade-record types and framing constants for the ITCH trade serializer.
package itch_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         REC_BYTES = 19;
  localparam int         FRAME_W   = REC_BYTES * 8;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [63:0] order_id;
    logic [31:0] volume;
    logic [31:0] price;
  } trade_rec_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_e;

  // Full wire frame: sync, payload in struct order (big-endian), XOR of payload bytes.
  function automatic logic [FRAME_W-1:0] build_frame(input trade_rec_t rec);
    logic [$bits(trade_rec_t)-1:0] bits;
    logic [7:0]                    csum;
    bits = rec;
    csum = 8'h00;
    for (int i = 0; i < REC_BYTES - 2; i++) begin
      csum = csum ^ bits[i*8 +: 8];
    end
    return {SYNC_BYTE, bits, csum};
  endfunction

endpackage

// File: rtl/trade_fifo.sv
// Synchronous trade-record FIFO; a pop on the same edge frees room for a push when full.
module trade_fifo
  import itch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  trade_rec_t             din,
  input  logic                   pop,
  output trade_rec_t             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  trade_rec_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trade_serializer.sv
// Queues trade records and streams each as a 19-byte checksummed frame with valid/ready.
//   state  | meaning
//   S_IDLE | no record loaded, out_valid low
//   S_SEND | shift register holds a frame, out_byte valid
module trade_serializer
  import itch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   field_valid,
  input  logic [7:0]             msg_type,
  input  logic [63:0]            order_id,
  input  logic [31:0]            price,
  input  logic [31:0]            volume,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  ser_state_e         state_q, state_d;
  trade_rec_t         push_rec;
  trade_rec_t         head_rec;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               load;
  logic               advance;
  logic               last_byte;
  logic [FRAME_W-1:0] sreg;
  logic [4:0]         idx;

  assign push_rec  = {msg_type, order_id, volume, price};
  assign last_byte = (idx == 5'(REC_BYTES - 1));

  trade_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (field_valid),
    .din   (push_rec),
    .pop   (pop),
    .dout  (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          // Chain straight into the next queued record so there is no idle bubble.
          if (last_byte && !fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            advance = 1'b1;
            if (last_byte) state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shifting out the final byte leaves sreg zeroed, so out_byte idles at 8'h00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= build_frame(head_rec);
      idx  <= '0;
    end else if (advance) begin
      sreg <= {sreg[FRAME_W-9:0], 8'h00};
      idx  <= idx + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (field_valid && fifo_full && !pop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign out_valid = (state_q == S_SEND);
  assign out_last  = out_valid && last_byte;
  assign out_byte  = sreg[FRAME_W-1 -: 8];

endmodule

// File: tb/tb_trade_serializer.sv
// Directed self-checking bench for trade_serializer (DEPTH=4).
module tb_trade_serializer;

  logic        clk;
  logic        rst_n;
  logic        field_valid;
  logic [7:0]  msg_type;
  logic [63:0] order_id;
  logic [31:0] price;
  logic [31:0] volume;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] drop_cnt;
  logic [2:0]  fifo_level;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  exp_q [$];
  logic [7:0]  tr_type  [6];
  logic [63:0] tr_oid   [6];
  logic [31:0] tr_vol   [6];
  logic [31:0] tr_price [6];

  // Hand-computed frame for trade 0; checksum 0x31 is the XOR of bytes 1..17.
  logic [7:0] t0_frame [19] = '{8'hA5, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                8'h07, 8'h08, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h0F,
                                8'h42, 8'h40, 8'h31};

  trade_serializer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .field_valid (field_valid),
    .msg_type    (msg_type),
    .order_id    (order_id),
    .price       (price),
    .volume      (volume),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .drop_cnt    (drop_cnt),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_trade(input int k);
    msg_type    = tr_type[k];
    order_id    = tr_oid[k];
    volume      = tr_vol[k];
    price       = tr_price[k];
    field_valid = 1'b1;
    tick();
    field_valid = 1'b0;
  endtask

  task automatic push_exp(input int k);
    logic [7:0] b [19];
    logic [7:0] cs;
    b[0] = 8'hA5;
    b[1] = tr_type[k];
    for (int i = 0; i < 8; i++) b[2+i]  = tr_oid[k][63-8*i -: 8];
    for (int i = 0; i < 4; i++) b[10+i] = tr_vol[k][31-8*i -: 8];
    for (int i = 0; i < 4; i++) b[14+i] = tr_price[k][31-8*i -: 8];
    cs = 8'h00;
    for (int i = 1; i < 18; i++) cs = cs ^ b[i];
    b[18] = cs;
    for (int i = 0; i < 19; i++) exp_q.push_back(b[i]);
  endtask

  task automatic recv(input string name, input int n, input bit toggle, output int gaps);
    int         got;
    int         cyc;
    bit         stalled;
    bit         tgl;
    logic [7:0] pb;
    logic       pl;
    logic [7:0] e;
    got = 0; cyc = 0; gaps = 0; stalled = 0; tgl = 0; pb = 8'h00; pl = 1'b0;
    while (got < n && cyc < n * 4 + 40) begin
      out_ready = toggle ? tgl : 1'b1;
      tgl = ~tgl;
      if (out_valid) begin
        if (stalled) begin
          n_cmp++;
          if (out_byte !== pb || out_last !== pl) begin
            n_fail++;
            $display("FAIL %s hold: byte %h last %b, required %h %b", name, out_byte, out_last, pb, pl);
          end
        end
        if (out_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          n_cmp++;
          if (out_byte !== e) begin
            n_fail++;
            $display("FAIL %s byte %0d: got %h, required %h", name, got, out_byte, e);
          end
          n_cmp++;
          if (out_last !== ((got % 19) == 18)) begin
            n_fail++;
            $display("FAIL %s last %0d: got %b, required %b", name, got, out_last, (got % 19) == 18);
          end
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          pb = out_byte;
          pl = out_last;
        end
      end else if (got > 0) begin
        gaps++;
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s count: got %0d bytes, required %0d", name, got, n);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0)    begin n_fail++; $display("FAIL rst out_last: got %b, required 0", out_last); end
    n_cmp++; if (out_byte !== 8'h00)   begin n_fail++; $display("FAIL rst out_byte: got %h, required 00", out_byte); end
    n_cmp++; if (drop_cnt !== 16'h0)   begin n_fail++; $display("FAIL rst drop_cnt: got %h, required 0", drop_cnt); end
    n_cmp++; if (fifo_level !== 3'd0)  begin n_fail++; $display("FAIL rst fifo_level: got %0d, required 0", fifo_level); end
  endtask

  task automatic test_single();
    int g;
    out_ready = 1'b1;
    send_trade(0);
    n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL single N+1 valid: got %b, required 0", out_valid); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single N+1 level: got %0d, required 1", fifo_level); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_byte !== 8'hA5) begin
      n_fail++; $display("FAIL single N+2: valid %b byte %h, required 1 a5", out_valid, out_byte);
    end
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL single N+2 level: got %0d, required 0", fifo_level); end
    for (int i = 0; i < 19; i++) exp_q.push_back(t0_frame[i]);
    recv("single", 19, 1'b0, g);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single idle: valid %b, required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int g;
    out_ready = 1'b0;
    send_trade(0);
    for (int i = 0; i < 19; i++) exp_q.push_back(t0_frame[i]);
    recv("bp", 19, 1'b1, g);
  endtask

  task automatic test_back_to_back();
    int g;
    out_ready = 1'b0;
    send_trade(1);
    send_trade(2);
    send_trade(3);
    push_exp(1); push_exp(2); push_exp(3);
    recv("b2b", 57, 1'b0, g);
    n_cmp++; if (g != 0) begin n_fail++; $display("FAIL b2b gaps: got %0d, required 0", g); end
  endtask

  task automatic test_overflow();
    int g;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send_trade(k);
    tick();
    n_cmp++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf level: got %0d, required 4", fifo_level); end
    n_cmp++; if (drop_cnt !== 16'd1)  begin n_fail++; $display("FAIL ovf drop_cnt: got %0d, required 1", drop_cnt); end
    for (int k = 0; k < 5; k++) push_exp(k);
    recv("ovf", 95, 1'b0, g);
    n_cmp++; if (g != 0) begin n_fail++; $display("FAIL ovf gaps: got %0d, required 0", g); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovf drain level: got %0d, required 0", fifo_level); end
  endtask

  task automatic test_push_pop_full();
    int         g;
    int         cyc;
    logic [7:0] e;
    out_ready = 1'b0;
    for (int k = 1; k < 6; k++) send_trade(k);
    n_cmp++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full level: got %0d, required 4", fifo_level); end
    for (int k = 1; k < 6; k++) push_exp(k);
    out_ready = 1'b1;
    cyc = 0;
    while (!(out_valid && out_last) && cyc < 60) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_byte !== e) begin n_fail++; $display("FAIL full byte: got %h, required %h", out_byte, e); end
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (!(out_valid && out_last)) begin
      n_fail++; $display("FAIL full wait last: valid %b last %b, required 1 1", out_valid, out_last);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (out_byte !== e) begin n_fail++; $display("FAIL full last byte: got %h, required %h", out_byte, e); end
    end
    push_exp(0);
    send_trade(0);
    n_cmp++; if (drop_cnt !== 16'd1)  begin n_fail++; $display("FAIL full drop_cnt: got %0d, required 1", drop_cnt); end
    n_cmp++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full push-pop level: got %0d, required 4", fifo_level); end
    n_cmp++; if (out_valid !== 1'b1 || out_byte !== 8'hA5) begin
      n_fail++; $display("FAIL full no bubble: valid %b byte %h, required 1 a5", out_valid, out_byte);
    end
    recv("full", 95, 1'b0, g);
    n_cmp++; if (g != 0) begin n_fail++; $display("FAIL full gaps: got %0d, required 0", g); end
  endtask

  task automatic test_reset_mid();
    int         g;
    int         got;
    int         cyc;
    logic [7:0] e;
    out_ready = 1'b1;
    send_trade(2);
    push_exp(2);
    got = 0; cyc = 0;
    while (got < 7 && cyc < 40) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_byte !== e) begin n_fail++; $display("FAIL rmid byte %0d: got %h, required %h", got, out_byte, e); end
        got++;
      end
      tick();
      cyc++;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid at byte 7: valid %b, required 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rmid async valid: got %b, required 0", out_valid); end
    n_cmp++; if (drop_cnt !== 16'd0)  begin n_fail++; $display("FAIL rmid drop_cnt: got %0d, required 0", drop_cnt); end
    n_cmp++; if (out_byte !== 8'h00)  begin n_fail++; $display("FAIL rmid out_byte: got %h, required 00", out_byte); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rmid level: got %0d, required 0", fifo_level); end
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid after release: valid %b, required 0", out_valid); end
    send_trade(3);
    push_exp(3);
    recv("rmid", 19, 1'b0, g);
  endtask

  initial begin
    tr_type[0] = 8'h50; tr_oid[0] = 64'h0102030405060708; tr_vol[0] = 32'h00000064; tr_price[0] = 32'h000F4240;
    tr_type[1] = 8'h50; tr_oid[1] = 64'hDEADBEEF00112233; tr_vol[1] = 32'h000003E8; tr_price[1] = 32'h0001ADB0;
    tr_type[2] = 8'h51; tr_oid[2] = 64'h1122334455667788; tr_vol[2] = 32'h00000001; tr_price[2] = 32'hFFFFFFFF;
    tr_type[3] = 8'h50; tr_oid[3] = 64'h0000000000000000; tr_vol[3] = 32'h12345678; tr_price[3] = 32'h9ABCDEF0;
    tr_type[4] = 8'h45; tr_oid[4] = 64'hFFFFFFFFFFFFFFFF; tr_vol[4] = 32'h0000000A; tr_price[4] = 32'h00000005;
    tr_type[5] = 8'h50; tr_oid[5] = 64'h0A0B0C0D0E0F1011; tr_vol[5] = 32'h00000200; tr_price[5] = 32'h00C0FFEE;
    rst_n       = 1'b0;
    field_valid = 1'b0;
    msg_type    = 8'h00;
    order_id    = 64'h0;
    price       = 32'h0;
    volume      = 32'h0;
    out_ready   = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
